// File: rtl/vga_timing_decoder_if.sv
// Sync stream into the timing decoder and the recovered timing/status coming back out.
interface vga_timing_decoder_if;
  // pixel_valid and pixel_strobe are per-cycle qualifiers with no backpressure: a sample is
  // consumed on every enabled clock, and downstream logic must qualify pulses with clock_enable.
  logic       horizontal_sync;
  logic       vertical_sync;
  logic       pixel_valid;
  logic       locked;
  logic       pixel_strobe;
  logic [9:0] vga_col;
  logic [9:0] vga_row;
  logic       line_start;
  logic       frame_start;
  logic       timing_error;
  logic [7:0] error_count;
  logic [1:0] fsm_state;

  modport master (
    output horizontal_sync, vertical_sync, pixel_valid,
    input  locked, pixel_strobe, vga_col, vga_row, line_start, frame_start,
    input  timing_error, error_count, fsm_state
  );

  modport slave (
    input  horizontal_sync, vertical_sync, pixel_valid,
    output locked, pixel_strobe, vga_col, vga_row, line_start, frame_start,
    output timing_error, error_count, fsm_state
  );
endinterface

// File: rtl/vga_timing_decoder.sv
// Rebuilds column/row counters from an incoming VGA sync stream, verifies the timing
// and reports lock, active-pixel coordinates, line/frame strobes and violations.
module vga_timing_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_START = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_ACT_START = 35,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clock_enable,
  vga_timing_decoder_if.slave  vid
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0] H_AS     = 10'(H_ACT_START);
  localparam logic [9:0] H_AE     = 10'(H_ACT_START + H_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0] V_AS     = 10'(V_ACT_START);
  localparam logic [9:0] V_AE     = 10'(V_ACT_START + V_ACTIVE);
  localparam logic [7:0] GOOD_TGT = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] good_frames;
  logic       hs_r, vs_r, pv_r, hs_p, vs_p;
  logic [9:0] h_count, v_count;
  logic       locked_q, pixel_strobe_q, line_start_q, frame_start_q, timing_error_q;
  logic [9:0] vga_col_q, vga_row_q;
  logic [7:0] error_count_q;

  logic       hs_rise, hs_fall, vs_rise, vs_fall, h_wrap;
  logic [9:0] h_nx, v_nx;
  logic       exp_act, err_any, err_hit, lock_nx, strobe_nx;

  // h_nx/v_nx are the coordinates of the sample currently sitting in the input registers.
  always_comb begin
    hs_rise = hs_r & ~hs_p;
    hs_fall = ~hs_r & hs_p;
    vs_rise = vs_r & ~vs_p;
    vs_fall = ~vs_r & vs_p;
    h_wrap  = (h_count == H_LAST);
    h_nx    = (hs_rise || h_wrap) ? 10'd0 : h_count + 10'd1;
    v_nx    = v_count;
    if (hs_rise) v_nx = vs_rise ? 10'd0 : v_count + 10'd1;
    exp_act = (h_nx >= H_AS) && (h_nx < H_AE) && (v_nx >= V_AS) && (v_nx < V_AE);
    err_any = (hs_rise ? (h_count != H_LAST) : h_wrap)
            | (hs_fall && (h_count + 10'd1 != H_SYNC_W))
            | (vs_rise && !hs_rise)
            | (vs_rise && (v_count != V_LAST))
            | (vs_fall && !(hs_rise && (v_nx == V_SYNC_W)))
            | (pv_r != exp_act);
    err_hit = err_any && (state != UNLOCKED);
    lock_nx = 1'b0;
    if (state == LOCKED)
      lock_nx = !err_any;
    else if (state == ACQUIRE)
      lock_nx = !err_any && vs_rise && (good_frames + 8'd1 == GOOD_TGT);
    strobe_nx = pv_r && lock_nx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= UNLOCKED;
      good_frames    <= '0;
      hs_r           <= 1'b0;
      vs_r           <= 1'b0;
      pv_r           <= 1'b0;
      hs_p           <= 1'b0;
      vs_p           <= 1'b0;
      h_count        <= '0;
      v_count        <= '0;
      locked_q       <= 1'b0;
      pixel_strobe_q <= 1'b0;
      vga_col_q      <= '0;
      vga_row_q      <= '0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      timing_error_q <= 1'b0;
      error_count_q  <= '0;
    end else if (clock_enable) begin
      hs_r           <= vid.horizontal_sync;
      vs_r           <= vid.vertical_sync;
      pv_r           <= vid.pixel_valid;
      hs_p           <= hs_r;
      vs_p           <= vs_r;
      h_count        <= h_nx;
      v_count        <= v_nx;
      line_start_q   <= hs_rise;
      frame_start_q  <= vs_rise;
      timing_error_q <= err_hit;
      locked_q       <= lock_nx;
      pixel_strobe_q <= strobe_nx;
      vga_col_q      <= strobe_nx ? h_nx - H_AS : 10'd0;
      vga_row_q      <= strobe_nx ? v_nx - V_AS : 10'd0;
      if (err_hit && (error_count_q != 8'hFF))
        error_count_q <= error_count_q + 8'd1;
      // Violations merge into one pulse per cycle; any error in ACQUIRE/LOCKED forces reacquisition.
      case (state)
        UNLOCKED: begin
          if (vs_rise) begin
            state       <= ACQUIRE;
            good_frames <= '0;
          end
        end
        ACQUIRE: begin
          if (err_any) begin
            state <= UNLOCKED;
          end else if (vs_rise) begin
            good_frames <= good_frames + 8'd1;
            if (lock_nx) state <= LOCKED;
          end
        end
        LOCKED: begin
          if (err_any) state <= UNLOCKED;
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

  assign vid.locked       = locked_q;
  assign vid.pixel_strobe = pixel_strobe_q;
  assign vid.vga_col      = vga_col_q;
  assign vid.vga_row      = vga_row_q;
  assign vid.line_start   = line_start_q;
  assign vid.frame_start  = frame_start_q;
  assign vid.timing_error = timing_error_q;
  assign vid.error_count  = error_count_q;
  assign vid.fsm_state    = state;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder using a reduced 20x12 raster so whole frames stay short.
module tb_vga_timing_decoder;
  localparam int T_HT  = 20;
  localparam int T_HS  = 3;
  localparam int T_HAS = 5;
  localparam int T_HA  = 12;
  localparam int T_VT  = 12;
  localparam int T_VS  = 2;
  localparam int T_VAS = 3;
  localparam int T_VA  = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce  = 1'b0;
  always #5 clk = ~clk;

  vga_timing_decoder_if bus();

  vga_timing_decoder #(
    .H_TOTAL(T_HT), .H_SYNC(T_HS), .H_ACT_START(T_HAS), .H_ACTIVE(T_HA),
    .V_TOTAL(T_VT), .V_SYNC(T_VS), .V_ACT_START(T_VAS), .V_ACTIVE(T_VA),
    .LOCK_FRAMES(2)
  ) dut (
    .clock(clk),
    .reset(rst),
    .clock_enable(ce),
    .vid(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int fs_count = 0, ls_count = 0, te_count = 0, strobe_count = 0;
  int lock_fs = -1, frozen_bad = 0;
  logic lock_on_fs = 1'b0;
  logic prev_locked = 1'b0;
  logic [32:0] prev_snap = '0;
  logic [9:0] first_col = '0, first_row = '0, last_col = '0, last_row = '0;
  bit quarter = 1'b0;

  // One clock: drive pins, step past the edge, then record what the outputs did.
  task automatic tick(input logic hs, input logic vs, input logic pv, input logic en);
    logic [32:0] s;
    bus.horizontal_sync = hs;
    bus.vertical_sync   = vs;
    bus.pixel_valid     = pv;
    ce = en;
    @(posedge clk);
    #1;
    s = {bus.locked, bus.pixel_strobe, bus.vga_col, bus.vga_row, bus.line_start,
         bus.frame_start, bus.timing_error, bus.error_count};
    if (en) begin
      if (bus.frame_start) fs_count++;
      if (bus.line_start) ls_count++;
      if (bus.timing_error) te_count++;
      if (bus.pixel_strobe) begin
        if (strobe_count == 0) begin
          first_col = bus.vga_col;
          first_row = bus.vga_row;
        end
        last_col = bus.vga_col;
        last_row = bus.vga_row;
        strobe_count++;
      end
      if (bus.locked && !prev_locked) begin
        lock_fs    = fs_count;
        lock_on_fs = bus.frame_start;
      end
    end else if (s !== prev_snap) begin
      frozen_bad++;
    end
    prev_snap   = s;
    prev_locked = bus.locked;
  endtask

  task automatic pix(input logic hs, input logic vs, input logic pv);
    if (quarter) repeat (3) tick(hs, vs, pv, 1'b0);
    tick(hs, vs, pv, 1'b1);
  endtask

  task automatic send_line(input int v, input int len, input int hsw, input bit stuck);
    for (int h = 0; h < len; h++)
      pix(h < hsw, v < T_VS,
          stuck || (h >= T_HAS && h < T_HAS + T_HA && v >= T_VAS && v < T_VAS + T_VA));
  endtask

  task automatic send_frame(input int short_v, input int hsw_v, input int stuck_v);
    for (int v = 0; v < T_VT; v++)
      send_line(v, (v == short_v) ? T_HT - 1 : T_HT, (v == hsw_v) ? T_HS - 1 : T_HS, v == stuck_v);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    if (prev_snap !== 33'd0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", prev_snap); end
    vectors++;
    if (bus.fsm_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", bus.fsm_state); end
    vectors++;
    rst = 1'b0;
  endtask

  task automatic test_lock;
    int fs0, ls0;
    fs0 = fs_count; ls0 = ls_count; lock_fs = -1;
    repeat (3) send_frame(-1, -1, -1);
    if (lock_fs !== fs0 + 3) begin miscompares++; $display("FAIL lock_frame: got %0d want %0d", lock_fs - fs0, 3); end
    vectors++;
    if (lock_on_fs !== 1'b1) begin miscompares++; $display("FAIL lock_with_frame_start: got %b want 1", lock_on_fs); end
    vectors++;
    if (bus.locked !== 1'b1) begin miscompares++; $display("FAIL lock_level: got %b want 1", bus.locked); end
    vectors++;
    if (bus.fsm_state !== 2'd2) begin miscompares++; $display("FAIL lock_state: got %0d want 2", bus.fsm_state); end
    vectors++;
    if (bus.error_count !== 8'd0) begin miscompares++; $display("FAIL lock_errcnt: got %0d want 0", bus.error_count); end
    vectors++;
    if (te_count !== 0) begin miscompares++; $display("FAIL lock_err_pulses: got %0d want 0", te_count); end
    vectors++;
    if (fs_count - fs0 !== 3) begin miscompares++; $display("FAIL lock_frame_starts: got %0d want 3", fs_count - fs0); end
    vectors++;
    if (ls_count - ls0 !== 36) begin miscompares++; $display("FAIL lock_line_starts: got %0d want 36", ls_count - ls0); end
    vectors++;
  endtask

  task automatic test_active_trace;
    int fs0, ls0, te0;
    fs0 = fs_count; ls0 = ls_count; te0 = te_count; strobe_count = 0;
    send_frame(-1, -1, -1);
    if (strobe_count !== 72) begin miscompares++; $display("FAIL trace_strobes: got %0d want 72", strobe_count); end
    vectors++;
    if (first_col !== 10'd0 || first_row !== 10'd0) begin miscompares++; $display("FAIL trace_first: got %0d,%0d want 0,0", first_col, first_row); end
    vectors++;
    if (last_col !== 10'd11 || last_row !== 10'd5) begin miscompares++; $display("FAIL trace_last: got %0d,%0d want 11,5", last_col, last_row); end
    vectors++;
    if (fs_count - fs0 !== 1 || ls_count - ls0 !== 12) begin miscompares++; $display("FAIL trace_strobes_fs_ls: got %0d,%0d want 1,12", fs_count - fs0, ls_count - ls0); end
    vectors++;
    if (te_count !== te0 || bus.locked !== 1'b1) begin miscompares++; $display("FAIL trace_clean: got err %0d lock %b want 0 1", te_count - te0, bus.locked); end
    vectors++;
  endtask

  task automatic test_short_line;
    int te0, fs0;
    te0 = te_count;
    send_frame(5, -1, -1);
    if (te_count - te0 !== 1) begin miscompares++; $display("FAIL short_pulses: got %0d want 1", te_count - te0); end
    vectors++;
    if (bus.error_count !== 8'd1) begin miscompares++; $display("FAIL short_errcnt: got %0d want 1", bus.error_count); end
    vectors++;
    if (bus.locked !== 1'b0 || bus.fsm_state !== 2'd0) begin miscompares++; $display("FAIL short_unlock: got lock %b state %0d want 0 0", bus.locked, bus.fsm_state); end
    vectors++;
    fs0 = fs_count; lock_fs = -1;
    repeat (3) send_frame(-1, -1, -1);
    if (lock_fs !== fs0 + 3 || bus.locked !== 1'b1) begin miscompares++; $display("FAIL short_relock: got %0d lock %b want 3 1", lock_fs - fs0, bus.locked); end
    vectors++;
  endtask

  task automatic test_sync_width_and_stuck;
    int te0;
    te0 = te_count;
    send_frame(-1, 1, -1);
    if (te_count - te0 !== 1 || bus.error_count !== 8'd2) begin miscompares++; $display("FAIL hsw_error: got %0d pulses cnt %0d want 1 2", te_count - te0, bus.error_count); end
    vectors++;
    if (bus.locked !== 1'b0) begin miscompares++; $display("FAIL hsw_unlock: got %b want 0", bus.locked); end
    vectors++;
    repeat (3) send_frame(-1, -1, -1);
    if (bus.locked !== 1'b1) begin miscompares++; $display("FAIL hsw_relock: got %b want 1", bus.locked); end
    vectors++;
    te0 = te_count;
    send_frame(-1, -1, 10);
    if (te_count - te0 !== 1 || bus.error_count !== 8'd3) begin miscompares++; $display("FAIL stuck_error: got %0d pulses cnt %0d want 1 3", te_count - te0, bus.error_count); end
    vectors++;
  endtask

  task automatic test_error_saturation;
    int te0;
    te0 = te_count;
    repeat (10) begin
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
    end
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b1);
    if (te_count - te0 !== 10 || bus.error_count !== 8'd13) begin miscompares++; $display("FAIL merge_errors: got %0d pulses cnt %0d want 10 13", te_count - te0, bus.error_count); end
    vectors++;
    repeat (300) begin
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 1'b1, 1'b1);
    end
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b1);
    if (te_count - te0 !== 310) begin miscompares++; $display("FAIL sat_pulses: got %0d want 310", te_count - te0); end
    vectors++;
    if (bus.error_count !== 8'd255) begin miscompares++; $display("FAIL sat_errcnt: got %0d want 255", bus.error_count); end
    vectors++;
  endtask

  task automatic test_reset_midframe;
    int fs0;
    repeat (3) send_frame(-1, -1, -1);
    if (bus.locked !== 1'b1) begin miscompares++; $display("FAIL mid_prelock: got %b want 1", bus.locked); end
    vectors++;
    for (int v = 0; v < 6; v++) send_line(v, T_HT, T_HS, 1'b0);
    for (int h = 0; h < 10; h++) pix(h < T_HS, 1'b0, h >= T_HAS);
    if (bus.pixel_strobe !== 1'b1 || bus.vga_col !== 10'd3 || bus.vga_row !== 10'd3) begin miscompares++; $display("FAIL mid_coord: got %b %0d,%0d want 1 3,3", bus.pixel_strobe, bus.vga_col, bus.vga_row); end
    vectors++;
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    if (prev_snap !== 33'd0 || bus.fsm_state !== 2'd0) begin miscompares++; $display("FAIL mid_reset: got %h state %0d want 0 0", prev_snap, bus.fsm_state); end
    vectors++;
    fs0 = fs_count; lock_fs = -1;
    repeat (3) send_frame(-1, -1, -1);
    if (lock_fs !== fs0 + 3 || bus.locked !== 1'b1) begin miscompares++; $display("FAIL mid_relock: got %0d lock %b want 3 1", lock_fs - fs0, bus.locked); end
    vectors++;
  endtask

  task automatic test_clock_enable;
    int fs0;
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    quarter = 1'b1; frozen_bad = 0;
    fs0 = fs_count; lock_fs = -1;
    repeat (3) send_frame(-1, -1, -1);
    if (lock_fs !== fs0 + 3 || lock_on_fs !== 1'b1) begin miscompares++; $display("FAIL ce_lock_frame: got %0d on_fs %b want 3 1", lock_fs - fs0, lock_on_fs); end
    vectors++;
    if (bus.error_count !== 8'd0) begin miscompares++; $display("FAIL ce_errcnt: got %0d want 0", bus.error_count); end
    vectors++;
    strobe_count = 0;
    send_frame(-1, -1, -1);
    if (strobe_count !== 72) begin miscompares++; $display("FAIL ce_strobes: got %0d want 72", strobe_count); end
    vectors++;
    if (first_col !== 10'd0 || first_row !== 10'd0 || last_col !== 10'd11 || last_row !== 10'd5) begin miscompares++; $display("FAIL ce_coords: got %0d,%0d..%0d,%0d want 0,0..11,5", first_col, first_row, last_col, last_row); end
    vectors++;
    if (frozen_bad !== 0) begin miscompares++; $display("FAIL ce_frozen: got %0d changes want 0", frozen_bad); end
    vectors++;
    quarter = 1'b0;
  endtask

  initial begin
    bus.horizontal_sync = 1'b0;
    bus.vertical_sync   = 1'b0;
    bus.pixel_valid     = 1'b0;
    test_reset();
    test_lock();
    test_active_trace();
    test_short_line();
    test_sync_width_and_stuck();
    test_error_saturation();
    test_reset_midframe();
    test_clock_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
